uart_tx: RTL

Serial transmitter that drains the TX FIFO and sends each byte as an asynchronous 8N1 frame, LSB first, on the UART output line. It is the far end of the TX FIFO: the ALU interface pushes results in, and this block pops them. Bit timing comes from the existing baud-rate tick generator, which supplies 16 ticks per bit period.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx.sv | 109 ++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud oversampling constants.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SB_TICKS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: pops bytes from a first-word-fall-through FIFO
// and shifts them out LSB first, timed by a 16x baud tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICKS   = SB_TICKS_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic [DATA_WIDTH-1:0] i_txff_data,
    input  logic                  i_txff_empty,
    output logic                  o_txff_read,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int TICK_MAX = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = $clog2(DATA_WIDTH) + 1;

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    state_t                state;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    // o_tx is assigned from the next state so the line moves with the state
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_tx        <= 1'b1;
            o_txff_read <= 1'b0;
            o_tx_busy   <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_txff_read <= 1'b0;
            o_tx_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (!i_txff_empty) begin
                        state       <= FETCH;
                        o_txff_read <= 1'b1;
                        o_tx_busy   <= 1'b1;
                    end
                end
                FETCH: begin
                    shreg    <= i_txff_data;
                    tick_cnt <= '0;
                    state    <= START;
                    o_tx     <= 1'b0;
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                            o_tx     <= shreg[0];
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == OS_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg >> 1;
                            bit_cnt  <= bit_cnt + BW'(1);
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                                o_tx  <= 1'b1;
                            end else begin
                                o_tx  <= shreg[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                STOP: begin
                    o_tx <= 1'b1;
                    if (i_tick) begin
                        if (tick_cnt == SB_LAST) begin
                            tick_cnt  <= '0;
                            state     <= IDLE;
                            o_tx_done <= 1'b1;
                            o_tx_busy <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
